fifo_in: RTL and testbench

// - Input-side FIFO: AXI-Stream slave accepts words from the upstream producer, buffers them,
//   and presents them show-ahead to the internal datapath, which pops with rd_en.
// - Sits between the system AXIS source and the compute core, mirroring the output FIFO at the far end.
// - Stores TLAST with each word so the core can see frame boundaries.

---
 rtl/fifo_in.sv | 76 +++++++
 tb/tb_fifo_in.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_in.sv
// rtl/fifo_in.sv - input-side show-ahead FIFO: AXIS slave in, rd_en pop out, TLAST kept per word
module fifo_in #(
  parameter int INW         = 24,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INW-1:0]               AXIS_TDATA,
  input  logic                         AXIS_TVALID,
  input  logic                         AXIS_TLAST,
  output logic                         AXIS_TREADY,
  input  logic                         rd_en,
  output logic [INW-1:0]               data_out,
  output logic                         last_out,
  output logic                         empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [INW:0]    mem [DEPTH];
  logic [INW:0]    head_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_next;
  logic            push;
  logic            pop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign AXIS_TREADY = (count < FULL_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AFULL_CNT);

  assign push    = AXIS_TVALID & AXIS_TREADY;
  assign pop     = rd_en & ~empty;
  assign rd_next = pop ? wrap_inc(rd_ptr) : rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {AXIS_TLAST, AXIS_TDATA};
  end

  // Head register always tracks the entry at rd_next; a word landing there this cycle is forwarded.
  always_ff @(posedge clk) begin
    if (push && (wr_ptr == rd_next)) head_q <= {AXIS_TLAST, AXIS_TDATA};
    else                             head_q <= mem[rd_next];
  end

  assign {last_out, data_out} = head_q;

endmodule

// File: tb/tb_fifo_in.sv
// tb/tb_fifo_in.sv - directed self-checking bench for fifo_in (DEPTH=16 and DEPTH=5 instances)
module tb_fifo_in;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic        rd_en = 1'b0;
  logic [23:0] data_out;
  logic        last_out;
  logic        empty;
  logic        almost_full;
  logic [4:0]  count;

  logic [23:0] tdata5 = '0;
  logic        tvalid5 = 1'b0;
  logic        tlast5 = 1'b0;
  logic        tready5;
  logic        rd_en5 = 1'b0;
  logic [23:0] data_out5;
  logic        last_out5;
  logic        empty5;
  logic        almost_full5;
  logic [2:0]  count5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_in #(.INW(24), .DEPTH(16), .AFULL_LEVEL(12)) u_dut (
    .clk(clk), .reset(reset),
    .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast), .AXIS_TREADY(tready),
    .rd_en(rd_en), .data_out(data_out), .last_out(last_out),
    .empty(empty), .almost_full(almost_full), .count(count)
  );

  fifo_in #(.INW(24), .DEPTH(5), .AFULL_LEVEL(4)) u_dut5 (
    .clk(clk), .reset(reset),
    .AXIS_TDATA(tdata5), .AXIS_TVALID(tvalid5), .AXIS_TLAST(tlast5), .AXIS_TREADY(tready5),
    .rd_en(rd_en5), .data_out(data_out5), .last_out(last_out5),
    .empty(empty5), .almost_full(almost_full5), .count(count5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the negedge; the DUT acts on the posedge between.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int wr_val;
    int rd_val;
    int q5[$];
    int d5;
    logic [19:0] pv;
    logic [19:0] pr;
    logic p5_push;
    logic p5_pop;

    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_tready", 32'(tready), 1);
    check("rst_afull", 32'(almost_full), 0);

    // three words, TLAST on the third
    for (int i = 1; i <= 3; i++) begin
      tvalid = 1'b1;
      tdata  = 24'(i);
      tlast  = (i == 3);
      step();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    check("p3_count", 32'(count), 3);
    check("p3_empty", 32'(empty), 0);
    for (int i = 1; i <= 3; i++) begin
      check("p3_data", 32'(data_out), 32'(i));
      check("p3_last", 32'(last_out), (i == 3) ? 1 : 0);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check("p3_drained", 32'(empty), 1);

    // fill to DEPTH
    for (int i = 0; i < 16; i++) begin
      check("fill_afull", 32'(almost_full), (i >= 12) ? 1 : 0);
      check("fill_tready", 32'(tready), 1);
      tvalid = 1'b1;
      tdata  = 24'h100 + 24'(i);
      step();
    end
    check("full_count", 32'(count), 16);
    check("full_tready", 32'(tready), 0);
    check("full_afull", 32'(almost_full), 1);
    tdata = 24'hBAD;
    step();
    step();
    check("full_hold", 32'(count), 16);
    check("full_head", 32'(data_out), 32'h100);
    rd_en = 1'b1;
    step();
    rd_en  = 1'b0;
    tvalid = 1'b0;
    check("unfull_tready", 32'(tready), 1);
    check("unfull_count", 32'(count), 15);
    for (int i = 1; i < 16; i++) begin
      check("drain_data", 32'(data_out), 32'h100 + 32'(i));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(empty), 1);

    // steady push+pop at count=5
    wr_val = 32'h200;
    rd_val = 32'h200;
    for (int i = 0; i < 5; i++) begin
      tvalid = 1'b1;
      tdata  = 24'(wr_val);
      wr_val++;
      step();
    end
    check("stream_pre", 32'(count), 5);
    for (int i = 0; i < 40; i++) begin
      check("stream_data", 32'(data_out), 32'(rd_val));
      tvalid = 1'b1;
      tdata  = 24'(wr_val);
      rd_en  = 1'b1;
      step();
      wr_val++;
      rd_val++;
      check("stream_count", 32'(count), 5);
    end
    tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stream_tail", 32'(data_out), 32'(rd_val));
      rd_val++;
      step();
    end
    rd_en = 1'b0;
    check("stream_empty", 32'(empty), 1);

    // push into empty with rd_en asserted: rd_en ignored, bypass delivers the word
    tvalid = 1'b1;
    tdata  = 24'hABCDEF;
    tlast  = 1'b1;
    rd_en  = 1'b1;
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
    rd_en  = 1'b0;
    check("byp_count", 32'(count), 1);
    check("byp_data", 32'(data_out), 32'hABCDEF);
    check("byp_last", 32'(last_out), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("byp_empty", 32'(empty), 1);

    // DEPTH=5 instance, mixed push/pop stalls against a queue model
    pv = 20'b1111_1101_1011_0111_0111;
    pr = 20'b0101_1010_1101_1011_0000;
    d5 = 32'h500;
    for (int i = 0; i < 20; i++) begin
      check("d5_tready", 32'(tready5), (q5.size() < 5) ? 1 : 0);
      if (q5.size() > 0) check("d5_data", 32'(data_out5), 32'(q5[0]));
      p5_push = pv[i] && (q5.size() < 5);
      p5_pop  = pr[i] && (q5.size() > 0);
      tvalid5 = pv[i];
      rd_en5  = pr[i];
      tdata5  = 24'(d5);
      step();
      if (p5_pop) void'(q5.pop_front());
      if (p5_push) begin
        q5.push_back(d5);
        d5++;
      end
      check("d5_count", 32'(count5), 32'(q5.size()));
    end
    tvalid5 = 1'b0;
    while (q5.size() > 0) begin
      check("d5_drain", 32'(data_out5), 32'(q5[0]));
      rd_en5 = 1'b1;
      step();
      void'(q5.pop_front());
    end
    rd_en5 = 1'b0;
    check("d5_empty", 32'(empty5), 1);

    // reset mid-stream at count=7 discards everything
    for (int i = 0; i < 7; i++) begin
      tvalid = 1'b1;
      tdata  = 24'h300 + 24'(i);
      step();
    end
    tvalid = 1'b0;
    check("mid_count", 32'(count), 7);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_tready", 32'(tready), 1);
    tvalid = 1'b1;
    tdata  = 24'h400;
    step();
    tvalid = 1'b0;
    check("post_rst_data", 32'(data_out), 32'h400);
    check("post_rst_count", 32'(count), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_rst_empty", 32'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
